// File: rtl/megaram_mem_seq_pkg.sv
// ---------------------------------------------------------------------------
// megaram_pkg
// Shared definitions for the MegaRAM memory access sequencer:
//   seq_state_t          - sequencer state encoding
//   FLOAT_BYTE           - value returned on the bus when no data is available
//   DEFAULT_TIMEOUT_CYC  - default clk cycles to wait for mem_ack
//   ADDR_W               - mapper physical address width
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package megaram_pkg;

    localparam int         ADDR_W              = 23;
    localparam int         DEFAULT_TIMEOUT_CYC = 64;
    localparam logic [7:0] FLOAT_BYTE          = 8'hFF;

    typedef enum logic [1:0] {
        SEQ_IDLE     = 2'd0,
        SEQ_ISSUE    = 2'd1,
        SEQ_WAIT_ACK = 2'd2,
        SEQ_HOLD     = 2'd3
    } seq_state_t;

endpackage

// File: rtl/megaram_mem_seq_if.sv
// ---------------------------------------------------------------------------
// megaram_mem_seq_if
// Request/acknowledge port between the sequencer and the memory controller.
//   mem_req   - request, held until the mem_ack cycle
//   mem_we    - write qualifier
//   mem_a     - physical address
//   mem_wdata - write data
//   mem_ack   - one-cycle completion pulse
//   mem_rdata - read data, valid with mem_ack
// master: the sequencer side. slave: the memory controller side.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface megaram_mem_seq_if;

    logic                            mem_req;
    logic                            mem_we;
    logic [megaram_pkg::ADDR_W-1:0]  mem_a;
    logic [7:0]                      mem_wdata;
    logic                            mem_ack;
    logic [7:0]                      mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_a,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_a,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/megaram_mem_seq_sync.sv
// ---------------------------------------------------------------------------
// megaram_sync2
// Multi-stage flip-flop synchronizer for a single asynchronous bit.
//   clk       - destination clock
//   reset_n   - asynchronous active-low reset, loads RESET_VAL into all stages
//   d_i       - asynchronous input
//   q_o       - synchronized output (STAGES clk of latency)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module megaram_sync2 #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/megaram_mem_seq.sv
// ---------------------------------------------------------------------------
// megaram_mem_seq
// Turns a cartridge-window Z80 bus cycle (qualified by the mapper) into one
// handshaked request on the external memory port, returns read data and
// holds the Z80 in WAIT until the data is valid.
//
// Parameters:
//   TIMEOUT_CYC  - WAIT_ACK cycles before an access is abandoned
//   SYNC_STAGES  - synchronizer depth for rd_n, wr_n and cart_ena
// Ports:
//   clk, reset_n          - system clock, async active-low reset
//   cart_ena, ram_ena     - mapper window hit / RAM mode
//   mem_addr, cdin        - mapped address and Z80 write data
//   rd_n, wr_n            - Z80 strobes (asynchronous)
//   cdout, cdout_oe       - read data and its drive enable
//   wait_n                - Z80 WAIT, active-low
//   timeout               - sticky timeout flag, cleared by reset only
//   mem                   - memory request port (megaram_mem_seq_if.master)
// Build option:
//   MEGARAM_SEQ_WRPOST_EN - write posting: writes never stall the Z80, and
//                           a start seen while a write is pending is queued.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module megaram_mem_seq
    import megaram_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cart_ena,
    input  logic              ram_ena,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic [7:0]        cdin,
    output logic [7:0]        cdout,
    output logic              cdout_oe,
    output logic              wait_n,
    output logic              timeout,
    megaram_mem_seq_if.master mem
);

    localparam logic [1:0] ST_IDLE     = 2'(SEQ_IDLE);
    localparam logic [1:0] ST_ISSUE    = 2'(SEQ_ISSUE);
    localparam logic [1:0] ST_WAIT_ACK = 2'(SEQ_WAIT_ACK);
    localparam logic [1:0] ST_HOLD     = 2'(SEQ_HOLD);

    localparam int             CNT_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic rdSync, wrSync, cartSync;

    logic [1:0]        state_q,     state_d;
    logic              memReq_q,    memReq_d;
    logic              memWe_q,     memWe_d;
    logic [ADDR_W-1:0] memA_q,      memA_d;
    logic [7:0]        memWdata_q,  memWdata_d;
    logic [7:0]        cdout_q,     cdout_d;
    logic              cdoutOe_q,   cdoutOe_d;
    logic              waitN_q,     waitN_d;
    logic              timeout_q,   timeout_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              isRead_q,    isRead_d;
    logic              rdPrev_q,    rdPrev_d;
    logic              wrPrev_q,    wrPrev_d;
`ifdef MEGARAM_SEQ_WRPOST_EN
    logic              pend_q,      pend_d;
    logic              pendRead_q,  pendRead_d;
    logic [ADDR_W-1:0] pendA_q,     pendA_d;
    logic [7:0]        pendWdata_q, pendWdata_d;
`endif

    logic rdFall, wrFall, startRead, startAccept, strobesHigh;
    logic startWaitN;

    megaram_sync2 #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) rdSyncInst (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (rd_n),
        .q_o     (rdSync)
    );

    megaram_sync2 #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) wrSyncInst (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (wr_n),
        .q_o     (wrSync)
    );

    megaram_sync2 #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) cartSyncInst (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (cart_ena),
        .q_o     (cartSync)
    );

    // A read wins whenever rd_n is low, so rd_n and wr_n low together is a
    // read. ROM-mode writes belong to the mapper's bank registers and are
    // never accepted here.
    assign rdFall      = rdPrev_q & ~rdSync;
    assign wrFall      = wrPrev_q & ~wrSync;
    assign startRead   = ~rdSync;
    assign startAccept = cartSync & (rdFall | wrFall) & (startRead | ram_ena);
    assign strobesHigh = rdSync & wrSync;

`ifdef MEGARAM_SEQ_WRPOST_EN
    assign startWaitN = ~startRead;
`else
    assign startWaitN = 1'b0;
`endif

    // The timeout counter only advances in WAIT_ACK; an ack on the same
    // cycle the last count is seen takes priority over the timeout.
    always_comb begin
        state_d    = state_q;
        memReq_d   = memReq_q;
        memWe_d    = memWe_q;
        memA_d     = memA_q;
        memWdata_d = memWdata_q;
        cdout_d    = cdout_q;
        cdoutOe_d  = cdoutOe_q;
        waitN_d    = waitN_q;
        timeout_d  = timeout_q;
        cnt_d      = cnt_q;
        isRead_d   = isRead_q;
        rdPrev_d   = rdSync;
        wrPrev_d   = wrSync;
`ifdef MEGARAM_SEQ_WRPOST_EN
        pend_d      = pend_q;
        pendRead_d  = pendRead_q;
        pendA_d     = pendA_q;
        pendWdata_d = pendWdata_q;
`endif

        case (state_q)
            ST_IDLE: begin
`ifdef MEGARAM_SEQ_WRPOST_EN
                if (pend_q) begin
                    state_d    = ST_ISSUE;
                    memReq_d   = 1'b1;
                    memWe_d    = ~pendRead_q;
                    memA_d     = pendA_q;
                    memWdata_d = pendWdata_q;
                    isRead_d   = pendRead_q;
                    waitN_d    = ~pendRead_q;
                    cdoutOe_d  = 1'b0;
                    cnt_d      = '0;
                    pend_d     = 1'b0;
                end else
`endif
                if (startAccept) begin
                    state_d    = ST_ISSUE;
                    memReq_d   = 1'b1;
                    memWe_d    = ~startRead;
                    memA_d     = mem_addr;
                    memWdata_d = cdin;
                    isRead_d   = startRead;
                    waitN_d    = startWaitN;
                    cdoutOe_d  = 1'b0;
                    cnt_d      = '0;
                end
            end

            ST_ISSUE, ST_WAIT_ACK: begin
                if (mem.mem_ack) begin
                    memReq_d = 1'b0;
                    waitN_d  = 1'b1;
                    // Data for a read whose strobe already rose is dropped.
                    if (isRead_q && !rdSync) begin
                        cdout_d   = mem.mem_rdata;
                        cdoutOe_d = 1'b1;
                    end
                    state_d = ST_HOLD;
`ifdef MEGARAM_SEQ_WRPOST_EN
                    if (!isRead_q) begin
                        state_d = ST_IDLE;
                    end
`endif
                end else if ((state_q == ST_WAIT_ACK) && (cnt_q == CNT_LAST)) begin
                    memReq_d  = 1'b0;
                    waitN_d   = 1'b1;
                    timeout_d = 1'b1;
                    if (isRead_q) begin
                        cdout_d   = FLOAT_BYTE;
                        cdoutOe_d = 1'b1;
                    end
                    state_d = ST_HOLD;
`ifdef MEGARAM_SEQ_WRPOST_EN
                    if (!isRead_q) begin
                        state_d = ST_IDLE;
                    end
`endif
                end else if (state_q == ST_ISSUE) begin
                    state_d = ST_WAIT_ACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`ifdef MEGARAM_SEQ_WRPOST_EN
                // A new cycle arriving behind a posted write is queued and
                // launched from IDLE once the write has finished; a queued
                // read stalls the Z80 from the moment it is seen.
                if (!isRead_q && !pend_q && startAccept) begin
                    pend_d      = 1'b1;
                    pendRead_d  = startRead;
                    pendA_d     = mem_addr;
                    pendWdata_d = cdin;
                    if (startRead) begin
                        waitN_d = 1'b0;
                    end
                end
`endif
            end

            ST_HOLD: begin
                if (strobesHigh) begin
                    cdoutOe_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            memReq_q    <= 1'b0;
            memWe_q     <= 1'b0;
            memA_q      <= '0;
            memWdata_q  <= '0;
            cdout_q     <= FLOAT_BYTE;
            cdoutOe_q   <= 1'b0;
            waitN_q     <= 1'b1;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
            isRead_q    <= 1'b0;
            rdPrev_q    <= 1'b1;
            wrPrev_q    <= 1'b1;
`ifdef MEGARAM_SEQ_WRPOST_EN
            pend_q      <= 1'b0;
            pendRead_q  <= 1'b0;
            pendA_q     <= '0;
            pendWdata_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            memReq_q    <= memReq_d;
            memWe_q     <= memWe_d;
            memA_q      <= memA_d;
            memWdata_q  <= memWdata_d;
            cdout_q     <= cdout_d;
            cdoutOe_q   <= cdoutOe_d;
            waitN_q     <= waitN_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
            isRead_q    <= isRead_d;
            rdPrev_q    <= rdPrev_d;
            wrPrev_q    <= wrPrev_d;
`ifdef MEGARAM_SEQ_WRPOST_EN
            pend_q      <= pend_d;
            pendRead_q  <= pendRead_d;
            pendA_q     <= pendA_d;
            pendWdata_q <= pendWdata_d;
`endif
        end
    end

    assign mem.mem_req   = memReq_q;
    assign mem.mem_we    = memWe_q;
    assign mem.mem_a     = memA_q;
    assign mem.mem_wdata = memWdata_q;
    assign cdout         = cdout_q;
    assign cdout_oe      = cdoutOe_q;
    assign wait_n        = waitN_q;
    assign timeout       = timeout_q;

endmodule

// File: doc/megaram_mem_seq.md
# megaram_mem_seq

Bus-to-memory access sequencer placed directly downstream of the MegaRAM/SCC mapper. It turns a cartridge-window Z80 bus cycle into a single handshaked request on the external memory port, using the mapper's `cart_ena`, `ram_ena` and 23-bit `mem_addr`. It returns read data on `cdout` and holds the Z80 in wait until the data is valid. Writes reach memory only in RAM mode; in ROM mode they belong to the mapper's bank registers.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 64: clk cycles to wait for `mem_ack` before abandoning an access.
- `SYNC_STAGES`, default 2: synchronizer depth applied to `rd_n`, `wr_n` and `cart_ena`.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `cart_ena` in 1: mapper reports a cartridge-window memory cycle (asynchronous to `clk`).
- `ram_ena` in 1: mapper is in RAM mode, so memory writes are permitted.
- `mem_addr` in 23: mapped physical address from the mapper.
- `rd_n`, `wr_n` in 1 each: Z80 strobes (asynchronous to `clk`).
- `cdin` in 8: Z80 write data.
- `cdout` out 8: read data to the bus.
- `cdout_oe` out 1: read data valid; the bus drives `cdout`.
- `wait_n` out 1: Z80 WAIT, active-low.
- `mem_req` out 1: request to the memory controller.
- `mem_we` out 1: write qualifier.
- `mem_a` out 23: memory address.
- `mem_wdata` out 8: memory write data.
- `mem_ack` in 1: one-cycle completion pulse.
- `mem_rdata` in 8: read data, valid on the `mem_ack` cycle.
- `timeout` out 1: sticky error flag; cleared by reset only.

## Operation
- `rd_n`, `wr_n` and `cart_ena` each pass through a `SYNC_STAGES` synchronizer. `mem_addr` and `cdin` are stable while a strobe is low and are sampled directly.
- Start condition: synchronized `cart_ena` is 1 and a synchronized strobe shows a 1→0 edge.
  - If both strobes are low at the same time, it is a read.
  - A write with `ram_ena`=0 is ignored: no request is issued and `wait_n` stays 1.
- States:
  - IDLE: waits for a start condition.
  - ISSUE: latches `mem_a`, `mem_we` and `mem_wdata`; drives `mem_req`=1; pulls `wait_n` low for a read.
  - WAIT_ACK: holds `mem_req` until `mem_ack`.
    - On a read, captures `mem_rdata` into `cdout` and sets `cdout_oe`=1.
    - On a timeout, forces `cdout`=8'hFF, sets `cdout_oe`=1 and sets `timeout`.
  - HOLD: `wait_n`=1; waits for both synchronized strobes to return high. On exit, `cdout_oe`=0 and the state goes to IDLE.
- `mem_req` stays high continuously from ISSUE until the `mem_ack` cycle, then drops the cycle after. Address and data do not change while `mem_req`=1.
- Timeout counter:
  - Counts WAIT_ACK cycles.
  - On reaching `TIMEOUT_CYC`, drops `mem_req` and goes to HOLD.
  - A later stray `mem_ack` is ignored.
- A strobe that rises before `mem_ack` does not abort the access. The request completes, read data is discarded, and HOLD exits immediately.
- A new start condition is only accepted from IDLE. Edges that occur in other states are lost by design, because the Z80 cannot issue overlapping cycles.

## Timing
Reset values:
- State IDLE.
- `mem_req`=0, `mem_we`=0, `mem_a`=0, `mem_wdata`=0.
- `cdout`=8'hFF, `cdout_oe`=0.
- `wait_n`=1.
- `timeout`=0.

Latencies:
- Strobe edge to `mem_req`: `SYNC_STAGES`+1 clk.
- `mem_ack` to `cdout_oe`=1 and `wait_n`=1: 1 clk (registered).

Other rules:
- `wait_n` goes low no later than `SYNC_STAGES`+1 clk after `rd_n` falls. At the 21 MHz system clock this is inside the Z80 T2 sampling window.
- Asserting `reset_n` mid-access returns all outputs to reset values immediately. Any outstanding `mem_ack` after reset is ignored.
- `mem_ack` arriving on the same cycle the timeout count is reached counts as success; `timeout` is not set.

## Configuration
- `MEGARAM_SEQ_WRPOST_EN` defined (write posting):
  - Writes never pull `wait_n` low.
  - A posted write that is still pending when the next start condition arrives is completed first. `wait_n` (for a read) is held low meanwhile.
- Macro undefined: writes pull `wait_n` low in ISSUE, exactly like reads, until `mem_ack` or timeout.

## Structure
- Shared package `megaram_pkg`:
  - state enumeration `seq_state_t`;
  - constant `FLOAT_BYTE`=8'hFF;
  - default `TIMEOUT_CYC`;
  - mapper address width 23.
- Sub-module `megaram_sync2`: a parameterized multi-stage synchronizer with reset value 1. It is instantiated for `rd_n` and `wr_n`; `cart_ena` uses reset value 0.

## Test plan
- Read: `cart_ena`=1, `mem_addr`=23'h420123, `rd_n` falls.
  - Expect `mem_req` with `mem_a`=23'h420123 and `mem_we`=0.
  - Memory acks after 5 clk with 8'h5A.
  - Expect `cdout`=8'h5A, `cdout_oe`=1 and `wait_n`=1 one clk later.
  - `cdout_oe`=0 after `rd_n` rises.
- ROM-mode write: `ram_ena`=0, `wr_n` falls with `cdin`=8'h07.
  - Expect no `mem_req` and `wait_n` constantly 1.
- RAM-mode write: `ram_ena`=1, `cdin`=8'hA5, address 23'h42E000.
  - Expect `mem_we`=1 and `mem_wdata`=8'hA5.
  - Macro defined: `wait_n` stays 1. Macro undefined: `wait_n` stays low until `mem_ack`.
- Timeout: read with no `mem_ack` for 64 clk.
  - Expect `mem_req` to drop, `cdout`=8'hFF, `timeout`=1 and `wait_n`=1.
  - A stray `mem_ack` afterwards causes no change.
- Reset during WAIT_ACK: all outputs return to reset values immediately, and the next read completes normally.
- Boundaries:
  - `mem_ack` on the exact timeout cycle: success, with `timeout` still 0.
  - `rd_n` and `wr_n` low together: treated as a read.
